// File: rtl/boron_rk_rev_buf_if.sv
// Stream and control bundle between the BORON key schedule, the round-key
// reversal buffer and the decryption key-addition stage.
interface boron_rk_rev_buf_if #(
    parameter int KEY_W = 64,
    parameter int IDX_W = 5
);
    logic             fill_start;
    logic             wr_valid;
    logic [KEY_W-1:0] wr_key;
    logic             play_start;
    logic             key_ready;
    logic             key_valid;
    logic [KEY_W-1:0] key_round;
    logic [IDX_W-1:0] key_idx;
    logic             full;
    logic [IDX_W-1:0] wr_count;
    logic             done;
    logic             ovf;

    modport master (
        output fill_start, wr_valid, wr_key, play_start, key_ready,
        input  key_valid, key_round, key_idx, full, wr_count, done, ovf
    );

    modport slave (
        input  fill_start, wr_valid, wr_key, play_start, key_ready,
        output key_valid, key_round, key_idx, full, wr_count, done, ovf
    );
endinterface

// File: rtl/boron_rk_rev_buf.sv
// Purpose: capture NUM_KEYS forward round keys, replay them NUM_KEYS-1..0; option BORON_RKBUF_CLEAR_EN.
// Latency: first key offered the cycle after play_start; one key per cycle thereafter.
// Backpressure: key_ready low holds the offered key/index stable; fill_start aborts at any time.
module boron_rk_rev_buf #(
    parameter int NUM_KEYS = 26,
    parameter int KEY_W    = 64,
    parameter int IDX_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    boron_rk_rev_buf_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
    localparam logic [1:0] S_PLAY = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    logic [1:0]       state;
    logic [KEY_W-1:0] mem [NUM_KEYS];
    logic             key_valid;
    logic [KEY_W-1:0] key_round;
    logic [IDX_W-1:0] key_idx;
    logic             full;
    logic [IDX_W-1:0] wr_count;
    logic             done;
    logic             ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            key_valid <= 1'b0;
            key_round <= '0;
            key_idx   <= '0;
            full      <= 1'b0;
            wr_count  <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            // fill_start outranks every other event, including a same-edge write
            if (bus.fill_start) begin
                state     <= S_FILL;
                wr_count  <= '0;
                full      <= 1'b0;
                key_valid <= 1'b0;
                ovf       <= 1'b0;
`ifdef BORON_RKBUF_CLEAR_EN
                key_round <= '0;
                for (int i = 0; i < NUM_KEYS; i++) begin
                    mem[i] <= '0;
                end
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.wr_valid) ovf <= 1'b1;
                    end
                    S_FILL: begin
                        if (bus.wr_valid) begin
                            mem[wr_count] <= bus.wr_key;
                            wr_count      <= wr_count + IDX_W'(1);
                            if (wr_count == LAST_IDX) begin
                                state <= S_FULL;
                                full  <= 1'b1;
                            end
                        end
                    end
                    S_FULL: begin
                        if (bus.wr_valid) ovf <= 1'b1;
                        if (bus.play_start) begin
                            state     <= S_PLAY;
                            key_valid <= 1'b1;
                            key_idx   <= LAST_IDX;
                            key_round <= mem[LAST_IDX];
                        end
                    end
                    default: begin
                        if (bus.wr_valid) ovf <= 1'b1;
                        if (bus.key_ready) begin
                            if (key_idx == '0) begin
                                state     <= S_FULL;
                                key_valid <= 1'b0;
                                done      <= 1'b1;
`ifdef BORON_RKBUF_CLEAR_EN
                                key_round <= '0;
`endif
                            end else begin
                                key_idx   <= key_idx - IDX_W'(1);
                                key_round <= mem[key_idx - IDX_W'(1)];
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.key_valid = key_valid;
    assign bus.key_round = key_round;
    assign bus.key_idx   = key_idx;
    assign bus.full      = full;
    assign bus.wr_count  = wr_count;
    assign bus.done      = done;
    assign bus.ovf       = ovf;
endmodule
